// File: rtl/hazard_scheduler_if.sv
// Decode/execute control bundle between the pipeline datapath and the hazard scheduler.
// The datapath side is the master; the scheduler consumes DEC/EX status and returns per-stage control.
interface hazard_scheduler_if #(
    parameter int REG_AW = 8,
    parameter int CNT_W  = 16
);
    logic              dec_valid;
    logic [REG_AW-1:0] dec_src_a;
    logic [REG_AW-1:0] dec_src_b;
    logic              dec_use_a;
    logic              dec_use_b;
    logic              dec_rwe;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_div;
    logic              ex_branch_taken;

    logic              hold_fetch;
    logic              flush_fetch;
    logic              bubble_ex;
    logic              hold_ex;
    logic              bubble_mem;
    logic              div_busy;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
               dec_rwe, dec_dst, dec_div, ex_branch_taken,
        input  hold_fetch, flush_fetch, bubble_ex, hold_ex, bubble_mem,
               div_busy, stall_count
    );

    modport slave (
        input  dec_valid, dec_src_a, dec_src_b, dec_use_a, dec_use_b,
               dec_rwe, dec_dst, dec_div, ex_branch_taken,
        output hold_fetch, flush_fetch, bubble_ex, hold_ex, bubble_mem,
               div_busy, stall_count
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Per-stage hold/bubble/flush controller for the 5-stage core: RAW scoreboard over EX/MEM/WB,
// multi-cycle divide sequencing and taken-branch squash.
module hazard_scheduler #(
    parameter int REG_AW     = 8,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scheduler_if.slave bus
);
    localparam int DCW = $clog2(DIV_CYCLES);

    typedef enum logic [0:0] {RUN, DIV} state_t;

    state_t            state_q, state_d;
    logic [DCW-1:0]    div_cnt_q, div_cnt_d;
    logic              ex_vld_q, mem_vld_q, wb_vld_q;
    logic [REG_AW-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
    logic [CNT_W-1:0]  stall_count_q;

    logic match_a, match_b, haz;
    logic hold_fetch_c, flush_fetch_c, bubble_ex_c, hold_ex_c, bubble_mem_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // WB still counts: the register file writes late and reads early in the same cycle.
    assign match_a = (ex_vld_q  && ex_dst_q  == bus.dec_src_a) ||
                     (mem_vld_q && mem_dst_q == bus.dec_src_a) ||
                     (wb_vld_q  && wb_dst_q  == bus.dec_src_a);
    assign match_b = (ex_vld_q  && ex_dst_q  == bus.dec_src_b) ||
                     (mem_vld_q && mem_dst_q == bus.dec_src_b) ||
                     (wb_vld_q  && wb_dst_q  == bus.dec_src_b);
    assign haz = bus.dec_valid & ((bus.dec_use_a & match_a) | (bus.dec_use_b & match_b));

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        hold_fetch_c  = 1'b0;
        flush_fetch_c = 1'b0;
        bubble_ex_c   = 1'b0;
        hold_ex_c     = 1'b0;
        bubble_mem_c  = 1'b0;
        case (state_q)
            RUN: begin
                flush_fetch_c = bus.ex_branch_taken;
                bubble_ex_c   = bus.ex_branch_taken | haz;
                hold_fetch_c  = haz & ~bus.ex_branch_taken;
                if (bus.dec_valid && bus.dec_div && !haz && !bus.ex_branch_taken) begin
                    state_d   = DIV;
                    div_cnt_d = DCW'(DIV_CYCLES - 1);
                end
            end
            DIV: begin
                // Any hazard or branch seen here is subsumed by the divide hold.
                hold_fetch_c = 1'b1;
                hold_ex_c    = 1'b1;
                bubble_mem_c = 1'b1;
                div_cnt_d    = div_cnt_q - DCW'(1);
                if (div_cnt_q == DCW'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // Inputs are ignored while reset is held so every control output reads 0.
        if (!rst_n) begin
            hold_fetch_c  = 1'b0;
            flush_fetch_c = 1'b0;
            bubble_ex_c   = 1'b0;
            hold_ex_c     = 1'b0;
            bubble_mem_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            div_cnt_q     <= '0;
            ex_vld_q      <= 1'b0;
            mem_vld_q     <= 1'b0;
            wb_vld_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            if (state_q == DIV) begin
                mem_vld_q <= 1'b0;
                wb_vld_q  <= mem_vld_q;
            end else begin
                wb_vld_q  <= mem_vld_q;
                mem_vld_q <= ex_vld_q;
                ex_vld_q  <= ~bubble_ex_c & bus.dec_valid & bus.dec_rwe;
            end
            if (hold_fetch_c) stall_count_q <= sat_inc(stall_count_q);
        end
    end

    // Destination fields are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        wb_dst_q <= mem_dst_q;
        if (state_q != DIV) begin
            mem_dst_q <= ex_dst_q;
            ex_dst_q  <= bus.dec_dst;
        end
    end

    assign bus.hold_fetch  = hold_fetch_c;
    assign bus.flush_fetch = flush_fetch_c;
    assign bus.bubble_ex   = bubble_ex_c;
    assign bus.hold_ex     = hold_ex_c;
    assign bus.bubble_mem  = bubble_mem_c;
    assign bus.div_busy    = (state_q == DIV);
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an interval-based model of instruction lifetimes.
module tb_hazard_scheduler;
    localparam int REG_AW     = 8;
    localparam int DIV_CYCLES = 8;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    hazard_scheduler_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_scheduler #(.REG_AW(REG_AW), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each issued writer is in flight from its first EX cycle s through s+len+1 (EX, MEM, WB).
    typedef struct {
        int dst;
        int s;
        int len;
    } wr_t;

    wr_t inflight[$];
    int  cyc = 0;
    int  div_first = 1;
    int  div_last = 0;
    int  sc_m = 0;

    function automatic bit reg_busy(input int r);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].dst == r && cyc >= inflight[i].s &&
                cyc <= inflight[i].s + inflight[i].len + 1)
                return 1'b1;
        return 1'b0;
    endfunction

    int  e_hf, e_ff, e_bex, e_hex, e_bm, e_busy;
    bit  m_haz, m_issue;
    wr_t w;

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight.delete();
            div_first = 1;
            div_last  = 0;
            sc_m      = 0;
            e_hf = 0; e_ff = 0; e_bex = 0; e_hex = 0; e_bm = 0; e_busy = 0;
            m_issue = 1'b0;
        end else begin
            e_busy = (cyc >= div_first && cyc <= div_last) ? 1 : 0;
            m_issue = 1'b0;
            if (e_busy == 1) begin
                e_hf = 1; e_ff = 0; e_bex = 0; e_hex = 1; e_bm = 1;
            end else begin
                m_haz = bus.dec_valid &&
                        ((bus.dec_use_a && reg_busy(int'(bus.dec_src_a))) ||
                         (bus.dec_use_b && reg_busy(int'(bus.dec_src_b))));
                e_ff  = bus.ex_branch_taken ? 1 : 0;
                e_bex = (bus.ex_branch_taken || m_haz) ? 1 : 0;
                e_hf  = (m_haz && !bus.ex_branch_taken) ? 1 : 0;
                e_hex = 0;
                e_bm  = 0;
                m_issue = bus.dec_valid && !m_haz && !bus.ex_branch_taken;
            end
        end
        chk("hold_fetch",  int'(bus.hold_fetch),  e_hf);
        chk("flush_fetch", int'(bus.flush_fetch), e_ff);
        chk("bubble_ex",   int'(bus.bubble_ex),   e_bex);
        chk("hold_ex",     int'(bus.hold_ex),     e_hex);
        chk("bubble_mem",  int'(bus.bubble_mem),  e_bm);
        chk("div_busy",    int'(bus.div_busy),    e_busy);
        chk("stall_count", int'(bus.stall_count), sc_m);
        if (rst_n) begin
            if (m_issue) begin
                if (bus.dec_rwe) begin
                    w.dst = int'(bus.dec_dst);
                    w.s   = cyc + 1;
                    w.len = bus.dec_div ? DIV_CYCLES : 1;
                    inflight.push_back(w);
                end
                if (bus.dec_div) begin
                    div_first = cyc + 1;
                    div_last  = cyc + DIV_CYCLES - 1;
                end
            end
            if (e_hf == 1 && sc_m < CNT_MAX) sc_m++;
            while (inflight.size() > 0 && inflight[0].s + inflight[0].len + 1 < cyc + 1)
                void'(inflight.pop_front());
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int a, input int b, input bit ua, input bit ub,
                         input bit rwe, input int dst, input bit dv, input bit br);
        bus.dec_valid       = v;
        bus.dec_src_a       = REG_AW'(a);
        bus.dec_src_b       = REG_AW'(b);
        bus.dec_use_a       = ua;
        bus.dec_use_b       = ub;
        bus.dec_rwe         = rwe;
        bus.dec_dst         = REG_AW'(dst);
        bus.dec_div         = dv;
        bus.ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        // Inputs asserted during reset must not reach the outputs.
        drive(1, 0, 0, 1, 1, 1, 0, 1, 1);
        @(negedge clk);
        chk("rst_flush", int'(bus.flush_fetch), 0);
        chk("rst_bubble", int'(bus.bubble_ex), 0);
        chk("rst_busy", int'(bus.div_busy), 0);
        chk("rst_count", int'(bus.stall_count), 0);
        step();
        rst_n = 1'b1;
        idle();
        step();
        step();

        // Back-to-back dependence on r5: three stall cycles.
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        @(negedge clk);
        chk("b2b_prod_hf", int'(bus.hold_fetch), 0);
        step();
        drive(1, 5, 0, 1, 0, 1, 6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_hf", int'(bus.hold_fetch), 1);
            chk("b2b_bex", int'(bus.bubble_ex), 1);
            step();
        end
        @(negedge clk);
        chk("b2b_issue", int'(bus.hold_fetch), 0);
        step();
        idle();
        @(negedge clk);
        chk("b2b_count", int'(bus.stall_count), 3);
        repeat (4) step();

        // r7 producer, independent, then consumer via src_b: two stalls.
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
        step();
        drive(1, 0, 7, 0, 1, 1, 9, 0, 0);
        @(negedge clk);
        chk("mem_hf0", int'(bus.hold_fetch), 1);
        step();
        @(negedge clk);
        chk("mem_hf1", int'(bus.hold_fetch), 1);
        step();
        @(negedge clk);
        chk("mem_issue", int'(bus.hold_fetch), 0);
        step();
        idle();
        @(negedge clk);
        chk("mem_count", int'(bus.stall_count), 5);
        repeat (4) step();

        // Same pattern with operand B unused: no stall.
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 8, 0, 0);
        step();
        drive(1, 0, 7, 0, 0, 1, 9, 0, 0);
        @(negedge clk);
        chk("nouse_hf", int'(bus.hold_fetch), 0);
        step();
        idle();
        @(negedge clk);
        chk("nouse_count", int'(bus.stall_count), 5);
        repeat (4) step();

        // DIV r3: seven busy cycles, follower enters EX on cycle 9.
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0);
        @(negedge clk);
        chk("div_issue_busy", int'(bus.div_busy), 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 10, 0, 0);
        for (int i = 0; i < DIV_CYCLES - 1; i++) begin
            @(negedge clk);
            chk("div_busy_on", int'(bus.div_busy), 1);
            chk("div_hold_ex", int'(bus.hold_ex), 1);
            chk("div_bub_mem", int'(bus.bubble_mem), 1);
            step();
        end
        @(negedge clk);
        chk("div_done_busy", int'(bus.div_busy), 0);
        chk("div_done_hf", int'(bus.hold_fetch), 0);
        step();
        idle();
        @(negedge clk);
        chk("div_count", int'(bus.stall_count), 12);
        repeat (4) step();

        // Taken branch squashes a consumer hazarded on the EX slot.
        drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step();
        drive(1, 4, 0, 1, 0, 1, 12, 0, 1);
        @(negedge clk);
        chk("br_flush", int'(bus.flush_fetch), 1);
        chk("br_bex", int'(bus.bubble_ex), 1);
        chk("br_hf", int'(bus.hold_fetch), 0);
        step();
        drive(1, 12, 0, 1, 0, 1, 13, 0, 0);
        @(negedge clk);
        chk("br_next_hf", int'(bus.hold_fetch), 0);
        chk("br_next_bex", int'(bus.bubble_ex), 0);
        step();
        idle();
        @(negedge clk);
        chk("br_count", int'(bus.stall_count), 12);
        repeat (4) step();

        // Reset on the third divide cycle, then a fresh full-length divide.
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0);
        step();
        idle();
        step();
        @(negedge clk);
        chk("rdiv_busy_pre", int'(bus.div_busy), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rdiv_busy", int'(bus.div_busy), 0);
        chk("rdiv_hf", int'(bus.hold_fetch), 0);
        chk("rdiv_hex", int'(bus.hold_ex), 0);
        chk("rdiv_bm", int'(bus.bubble_mem), 0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0);
        step();
        idle();
        for (int i = 0; i < DIV_CYCLES - 1; i++) begin
            @(negedge clk);
            chk("rdiv2_busy", int'(bus.div_busy), 1);
            step();
        end
        @(negedge clk);
        chk("rdiv2_end", int'(bus.div_busy), 0);
        chk("rdiv2_count", int'(bus.stall_count), 7);
        step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            step();
        end

        // Self-dependent divide stream: 10 of every 11 cycles stall, enough to saturate.
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        drive(1, 3, 0, 1, 0, 1, 3, 1, 0);
        repeat (73000) step();
        @(negedge clk);
        chk("sat_count", int'(bus.stall_count), CNT_MAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
